// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and defaults for the shared-register arbiter.
// State encodings are fixed so other blocks can decode them.
package shared_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OWNED   = 2'b01,
        ST_RELEASE = 2'b10
    } state_e;

    localparam int OWNER_W      = 3;
    localparam int DEF_N        = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker, first request at or after ptr (wrapping).
// Latency: 0 cycles. Backpressure: none, pure function of req/ptr.
// Build option: none (used identically with and without LOCK_TIMEOUT_EN).
module shared_reg_arbiter_rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [N-1:0]       pick_oh,
    output logic [OWNER_W-1:0] pick_idx,
    output logic               found
);

    int cand;

    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found         = 1'b1;
                pick_oh[cand] = 1'b1;
                pick_idx      = OWNER_W'(cand);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Purpose: round-robin ownership arbiter + write sequencer for one shared register (Q/Qn).
// Latency: grant 1 cycle after req sampled, write 1 cycle; one RELEASE dead cycle between owners.
// Backpressure: waiting requesters stall until IDLE; LOCK_TIMEOUT_EN enables MAX_HOLD preemption.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         we,
    input  logic [N*WIDTH-1:0]   din,
    output logic [N-1:0]         gnt,
    output logic [OWNER_W-1:0]   owner,
    output logic                 busy,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qn
);

    state_e               state, state_nxt;
    logic [OWNER_W-1:0]   ptr;
    logic [N-1:0]         pick_oh;
    logic [OWNER_W-1:0]   pick_idx;
    logic                 found;
    logic                 own_req, own_we, load, preempt;
    logic [WIDTH-1:0]     wdat;

    shared_reg_arbiter_rr_pick #(.N(N)) u_pick (
        .req      (req),
        .ptr      (ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .found    (found)
    );

    // gnt is one-hot while owned, so masking with it selects the owner's lanes
    assign own_req = |(req & gnt);
    assign own_we  = |(we & gnt);

    always_comb begin
        wdat = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) wdat = din[i*WIDTH +: WIDTH];
        end
    end

`ifdef LOCK_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt;

    assign preempt = (hold_cnt >= HOLD_W'(MAX_HOLD)) && |(req & ~gnt);

    // Counts owned cycles including the first; saturates so a sole owner never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == ST_IDLE) begin
            hold_cnt <= HOLD_W'(1);
        end else if (state == ST_OWNED && hold_cnt < HOLD_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE:    if (found) state_nxt = ST_OWNED;
            ST_OWNED: begin
                if (!own_req || preempt) state_nxt = ST_RELEASE;
                else                     load      = own_we;
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            q     <= '0;
        end else begin
            state <= state_nxt;
            if (load) q <= wdat;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt   <= pick_oh;
                        owner <= pick_idx;
                    end
                end
                ST_OWNED:   if (state_nxt == ST_RELEASE) gnt <= '0;
                ST_RELEASE: ptr <= (owner == OWNER_W'(N - 1)) ? '0 : owner + OWNER_W'(1);
                default:    gnt <= '0;
            endcase
        end
    end

    assign busy = (state == ST_OWNED);
    assign qn   = ~q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (N=4, WIDTH=8); timeout steps depend on LOCK_TIMEOUT_EN.
module tb_shared_reg_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  qn;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.N(4), .WIDTH(8), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .din   (din),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .q     (q),
        .qn    (qn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        int         o;

        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        din   = '0;
        #2;
        check("rst_q", q, 8'h00);
        check("rst_qn", qn, 8'hFF);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 3'd0);
        step();
        rst_n = 1'b1;

        // Round robin from ptr=0: each owner holds 2 cycles then drops
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            o     = k % 4;
            exp_g = 4'b0001 << o;
            step();
            check("rr_gnt", gnt, exp_g);
            check("rr_owner", owner, o);
            step();
            req[o] = 1'b0;
            step();
            check("rr_release_gnt", gnt, 4'b0000);
            check("rr_release_busy", busy, 1'b0);
            req = 4'b1111;
            step();
            check("rr_idle_gnt", gnt, 4'b0000);
        end
        req = 4'b0000;
        step();
        check("rr_end_gnt", gnt, 4'b0000);

        // Single requester write (ptr=1)
        req = 4'b0010;
        we  = 4'b0010;
        din = {8'h00, 8'h00, 8'h3C, 8'h00};
        step();
        check("single_gnt", gnt, 4'b0010);
        check("single_owner", owner, 3'd1);
        check("single_busy", busy, 1'b1);
        check("single_q_pre", q, 8'h00);
        step();
        check("single_q", q, 8'h3C);
        check("single_qn", qn, 8'hC3);
        req = 4'b0000;
        we  = 4'b0000;
        step();
        check("single_rel_gnt", gnt, 4'b0000);
        check("single_rel_q", q, 8'h3C);
        step();

        // Isolation: owner 2 with We[2]=0, others' We ignored
        req = 4'b0100;
        we  = 4'b1011;
        din = {8'hFF, 8'h11, 8'h55, 8'h77};
        step();
        check("iso_gnt", gnt, 4'b0100);
        check("iso_owner", owner, 3'd2);
        step();
        step();
        check("iso_q", q, 8'h3C);
        we = 4'b0100;
        step();
        check("iso_q_own", q, 8'h11);
        req = 4'b0000;
        we  = 4'b0000;
        step();
        step();

        // Wrap: ptr=3, Req=1001 -> 3 then 0
        req = 4'b1001;
        step();
        check("wrap_gnt3", gnt, 4'b1000);
        check("wrap_owner3", owner, 3'd3);
        req = 4'b0001;
        step();
        check("wrap_rel", gnt, 4'b0000);
        step();
        check("wrap_idle", gnt, 4'b0000);
        step();
        check("wrap_gnt0", gnt, 4'b0001);
        check("wrap_owner0", owner, 3'd0);
        req = 4'b0000;
        step();
        step();

        // Withdrawal: requester 2 drops before its grant arrives (ptr=1)
        req = 4'b0010;
        step();
        check("wd_gnt1", gnt, 4'b0010);
        req = 4'b0110;
        step();
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        step();
        check("wd_idle", gnt, 4'b0000);
        step();
        check("wd_none", gnt, 4'b0000);

        // Sole requester is never released
        req = 4'b0001;
        step();
        check("sole_gnt", gnt, 4'b0001);
        for (int k = 0; k < 12; k++) step();
        check("sole_hold", gnt, 4'b0001);
        req = 4'b0000;
        step();
        step();

        // Contention while owner 0 holds its request
        req = 4'b0001;
        step();
        req = 4'b0011;
        for (int k = 0; k < 7; k++) step();
        check("hold8_gnt", gnt, 4'b0001);
        we  = 4'b0001;
        din = {8'h00, 8'h00, 8'h00, 8'hEE};
        step();
`ifdef LOCK_TIMEOUT_EN
        check("to_release", gnt, 4'b0000);
        check("to_no_write", q, 8'h11);
        we = 4'b0000;
        step();
        check("to_idle", gnt, 4'b0000);
        step();
        check("to_gnt1", gnt, 4'b0010);
`else
        check("nto_keep", gnt, 4'b0001);
        check("nto_write", q, 8'hEE);
`endif

        // Reset mid-write clears immediately
        we  = 4'b0011;
        din = {8'h00, 8'h00, 8'hA5, 8'hA5};
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_q", q, 8'h00);
        check("midrst_qn", qn, 8'hFF);
        check("midrst_gnt", gnt, 4'b0000);
        check("midrst_busy", busy, 1'b0);
        req = 4'b0000;
        we  = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_q", q, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
